// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default widths for the data-memory arbiter.
//   state_e : arbiter FSM states (single accesses vs. loader-owned burst)
//   sel_e   : which side drives the memory pins in the current cycle
//   DEF_*   : default address / data / burst-length widths
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick with one priority flop.
//   clk_i, rst_ni     : clock, async active-low reset (priority resets to A)
//   req_a_i, req_b_i  : requests from side A (CPU) and side B (loader)
//   lock_i            : burst in progress; B wins whenever it requests, A only
//                       gets stall cycles, and priority is frozen
//   gnt_a_o, gnt_b_o  : one-hot-or-zero grants (combinational)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic lock_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_b_q, prio_b_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_a_o  = 1'b0;
        gnt_b_o  = 1'b0;
        prio_b_d = prio_b_q;
        if (lock_i) begin
            // The burst was entered by an unlocked B grant, which already
            // handed priority to A, so holding it here leaves A in front when
            // the burst ends.
            gnt_b_o = req_b_i;
            gnt_a_o = req_a_i & ~req_b_i;
        end else begin
            if (req_a_i && (!req_b_i || !prio_b_q)) begin
                gnt_a_o = 1'b1;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
            end
            if (gnt_a_o) begin
                prio_b_d = 1'b1;
            end else if (gnt_b_o) begin
                prio_b_d = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory array between the CPU load/store port (A) and the
// program/data loader port (B). Single accesses are arbitrated round-robin;
// loader bursts of b_len_i+1 beats are sequenced by an internal address
// counter. Read data returns one cycle after grant on a registered pair.
//   A port   : a_req_i, a_we_i, a_addr_i, a_dato_i -> a_gnt_o, a_rvalid_o, a_dato_o
//   B port   : b_req_i, b_we_i, b_addr_i, b_len_i, b_dato_i
//              -> b_gnt_o, b_rvalid_o, b_dato_o, b_done_o
//   Memory   : mem_writeen_o, mem_readen_o, mem_addr_o, mem_dato_o out,
//              mem_dato_i in (combinational read data)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_dato_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_dato_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [LEN_W-1:0]  b_len_i,
    input  logic [DATA_W-1:0] b_dato_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_dato_o,
    output logic              b_done_o,
    output logic              mem_writeen_o,
    output logic              mem_readen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_dato_o,
    input  logic [DATA_W-1:0] mem_dato_i
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;       // beats still to go after current
    logic [ADDR_W-1:0]   baddr_q, baddr_d;   // next burst beat address
    logic                bwe_q, bwe_d;       // direction sampled at burst start

    logic                a_rvalid_q, a_rvalid_d;
    logic [DATA_W-1:0]   a_dato_q, a_dato_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   b_dato_q, b_dato_d;

    logic                gnt_a, gnt_b;
    logic                b_we_eff;
    logic [ADDR_W-1:0]   b_addr_eff;
    logic                b_done;
    sel_e                sel;

    // Requests are masked while reset is held so every combinational output
    // is 0 from the moment reset asserts, even mid-burst.
    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_a_i (a_req_i & rst_ni),
        .req_b_i (b_req_i & rst_ni),
        .lock_i  (state_q == ST_BURST),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    // Inside a burst the loader's own fields are ignored in favour of the
    // sampled direction and the counter address.
    assign b_we_eff   = (state_q == ST_BURST) ? bwe_q   : b_we_i;
    assign b_addr_eff = (state_q == ST_BURST) ? baddr_q : b_addr_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        baddr_d = baddr_q;
        bwe_d   = bwe_q;
        b_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_b) begin
                    if (b_len_i == '0) begin
                        b_done = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        rem_d   = b_len_i;
                        baddr_d = b_addr_i + 1'b1;
                        bwe_d   = b_we_i;
                    end
                end
            end
            ST_BURST: begin
                // A stall cycle (no gnt_b) leaves the counter untouched.
                if (gnt_b) begin
                    baddr_d = baddr_q + 1'b1;   // wraps modulo 2^ADDR_W
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        b_done  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel = SEL_NONE;
        if (gnt_a) begin
            sel = SEL_A;
        end else if (gnt_b) begin
            sel = SEL_B;
        end
    end

    always_comb begin
        mem_writeen_o = 1'b0;
        mem_readen_o  = 1'b0;
        mem_addr_o    = '0;
        mem_dato_o    = '0;
        unique case (sel)
            SEL_A: begin
                mem_writeen_o = a_we_i;
                mem_readen_o  = ~a_we_i;
                mem_addr_o    = a_addr_i;
                mem_dato_o    = a_dato_i;
            end
            SEL_B: begin
                mem_writeen_o = b_we_eff;
                mem_readen_o  = ~b_we_eff;
                mem_addr_o    = b_addr_eff;
                mem_dato_o    = b_dato_i;
            end
            default: ;
        endcase
    end

    // Read returns: data captured only on a granted read, held otherwise.
    always_comb begin
        a_rvalid_d = gnt_a & ~a_we_i;
        b_rvalid_d = gnt_b & ~b_we_eff;
        a_dato_d   = a_rvalid_d ? mem_dato_i : a_dato_q;
        b_dato_d   = b_rvalid_d ? mem_dato_i : b_dato_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            baddr_q    <= '0;
            bwe_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            a_dato_q   <= '0;
            b_rvalid_q <= 1'b0;
            b_dato_q   <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            baddr_q    <= baddr_d;
            bwe_q      <= bwe_d;
            a_rvalid_q <= a_rvalid_d;
            a_dato_q   <= a_dato_d;
            b_rvalid_q <= b_rvalid_d;
            b_dato_q   <= b_dato_d;
        end
    end

    assign a_gnt_o    = gnt_a;
    assign b_gnt_o    = gnt_b;
    assign b_done_o   = b_done;
    assign a_rvalid_o = a_rvalid_q;
    assign a_dato_o   = a_dato_q;
    assign b_rvalid_o = b_rvalid_q;
    assign b_dato_o   = b_dato_q;

endmodule
